axi_bresp_allocator: RTL and testbench



---
 rtl/axi_bresp_allocator.sv | 124 ++++++++++++
 tb/tb_axi_bresp_allocator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_bresp_allocator.sv
// B-channel return path for one master-side port: round-robin merge of slave responses plus injected DECERR.
// Latency: one cycle from slave handshake (or error grant) to bvalid_o; one response per cycle sustained.
// Backpressure: the output register holds while bvalid_o & ~bready_i, and no bready_o/error_gnt_o is raised then.
module axi_bresp_allocator #(
    parameter int N_INIT_PORT = 8,
    parameter int AXI_ID_W    = 6,
    parameter int AXI_USER_W  = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_INIT_PORT-1:0]            bvalid_i,
    input  logic [N_INIT_PORT*AXI_ID_W-1:0]   bid_i,
    input  logic [N_INIT_PORT*2-1:0]          bresp_i,
    input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
    output logic [N_INIT_PORT-1:0]            bready_o,
    output logic                              bvalid_o,
    output logic [AXI_ID_W-1:0]               bid_o,
    output logic [1:0]                        bresp_o,
    output logic [AXI_USER_W-1:0]             buser_o,
    input  logic                              bready_i,
    input  logic                              error_req_i,
    input  logic [AXI_ID_W-1:0]               error_id_i,
    input  logic [AXI_USER_W-1:0]             error_user_i,
    output logic                              error_gnt_o
);

    localparam int                PTR_W  = $clog2(N_INIT_PORT);
    localparam logic [PTR_W:0]    N_L    = (PTR_W+1)'(N_INIT_PORT);
    localparam logic [PTR_W-1:0]  LAST_L = PTR_W'(N_INIT_PORT - 1);
    localparam logic [1:0]        DECERR = 2'b11;

    logic                  valid_q, valid_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [1:0]            resp_q, resp_d;
    logic [AXI_USER_W-1:0] user_q, user_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                  load_en;
    logic                  gnt_found;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W:0]        cand;

    // Register is free when empty or being popped this cycle.
    assign load_en = ~valid_q | bready_i;

    // Round-robin search: first valid slave at or above rr_ptr, wrapping past the last port.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_INIT_PORT; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= N_L) begin
                cand = cand - N_L;
            end
            if (!gnt_found && bvalid_i[cand[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Grants: error wins absolutely; nothing is granted while stalled or in reset.
    always_comb begin
        bready_o    = '0;
        error_gnt_o = 1'b0;
        if (!rst && load_en) begin
            if (error_req_i) begin
                error_gnt_o = 1'b1;
            end else if (gnt_found) begin
                bready_o[gnt_idx] = 1'b1;
            end
        end
    end

    // Next state of the output register and pointer; error grants leave rr_ptr untouched.
    always_comb begin
        valid_d  = valid_q;
        id_d     = id_q;
        resp_d   = resp_q;
        user_d   = user_q;
        rr_ptr_d = rr_ptr_q;
        if (load_en) begin
            if (error_req_i) begin
                valid_d = 1'b1;
                id_d    = error_id_i;
                resp_d  = DECERR;
                user_d  = error_user_i;
            end else if (gnt_found) begin
                valid_d  = 1'b1;
                id_d     = bid_i[gnt_idx*AXI_ID_W +: AXI_ID_W];
                resp_d   = bresp_i[gnt_idx*2 +: 2];
                user_d   = buser_i[gnt_idx*AXI_USER_W +: AXI_USER_W];
                rr_ptr_d = (gnt_idx == LAST_L) ? '0 : gnt_idx + 1'b1;
            end else begin
                // Nothing to load: drop valid, keep payload bits as they were.
                valid_d = 1'b0;
            end
        end
    end

    // State update with synchronous reset discarding any held response.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            id_q     <= '0;
            resp_q   <= '0;
            user_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            id_q     <= id_d;
            resp_q   <= resp_d;
            user_q   <= user_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bvalid_o = valid_q;
    assign bid_o    = id_q;
    assign bresp_o  = resp_q;
    assign buser_o  = user_q;

endmodule

// File: tb/tb_axi_bresp_allocator.sv
// Directed bench for axi_bresp_allocator: reset, round-robin order, stall, error injection, wrap, mid-run reset.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later, well before the next edge.
// Every expected value below is hand-derived from the block's behaviour, not read back from the DUT.
module tb_axi_bresp_allocator;

    localparam int N  = 8;
    localparam int IW = 6;
    localparam int UW = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     bvalid_i = '0;
    logic [N*IW-1:0]  bid_i;
    logic [N*2-1:0]   bresp_i;
    logic [N*UW-1:0]  buser_i;
    logic [N-1:0]     bready_o;
    logic             bvalid_o;
    logic [IW-1:0]    bid_o;
    logic [1:0]       bresp_o;
    logic [UW-1:0]    buser_o;
    logic             bready_i = 1'b0;
    logic             error_req_i = 1'b0;
    logic [IW-1:0]    error_id_i = '0;
    logic [UW-1:0]    error_user_i = '0;
    logic             error_gnt_o;

    logic [IW-1:0] tb_bid   [N];
    logic [1:0]    tb_bresp [N];
    logic [UW-1:0] tb_buser [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            bid_i[k*IW +: IW]   = tb_bid[k];
            bresp_i[k*2 +: 2]   = tb_bresp[k];
            buser_i[k*UW +: UW] = tb_buser[k];
        end
    end

    axi_bresp_allocator #(.N_INIT_PORT(N), .AXI_ID_W(IW), .AXI_USER_W(UW)) dut (
        .clk(clk), .rst(rst),
        .bvalid_i(bvalid_i), .bid_i(bid_i), .bresp_i(bresp_i), .buser_i(buser_i),
        .bready_o(bready_o),
        .bvalid_o(bvalid_o), .bid_o(bid_o), .bresp_o(bresp_o), .buser_o(buser_o),
        .bready_i(bready_i),
        .error_req_i(error_req_i), .error_id_i(error_id_i), .error_user_i(error_user_i),
        .error_gnt_o(error_gnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bvalid_i = '0; bready_i = 1'b0; error_req_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Reset values and first grant/response after reset release.
    task automatic test_reset();
        rst = 1'b1; bvalid_i = 8'hFF; bready_i = 1'b1;
        tick(); tick();
        settle();
        n_checks++; if (bvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid: got %b want 0", bvalid_o); end
        n_checks++; if (bready_o !== 8'h00) begin n_fail++; $display("FAIL reset_bready: got %h want 00", bready_o); end
        n_checks++; if ({bid_o, bresp_o, buser_o} !== 14'h0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", {bid_o, bresp_o, buser_o}); end
        error_req_i = 1'b1; settle();
        n_checks++; if (error_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_errgnt: got %b want 0", error_gnt_o); end
        error_req_i = 1'b0;
        tick();
        rst = 1'b0; settle();
        n_checks++; if (bready_o !== 8'h01) begin n_fail++; $display("FAIL post_reset_bready: got %h want 01", bready_o); end
        tick();
        n_checks++; if (bvalid_o !== 1'b1 || bid_o !== 6'h10) begin n_fail++; $display("FAIL post_reset_resp: got v=%b id=%h want v=1 id=10", bvalid_o, bid_o); end
        bvalid_i = '0;
    endtask

    // All slaves valid, master always ready: grants 0..7,0,1 with one response per cycle.
    task automatic test_round_robin();
        do_reset();
        bvalid_i = 8'hFF; bready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            n_checks++; if (bready_o !== 8'(1 << (c % 8))) begin n_fail++; $display("FAIL rr_grant c=%0d: got %h want %h", c, bready_o, 8'(1 << (c % 8))); end
            if (c >= 1) begin
                n_checks++;
                if (bvalid_o !== 1'b1 || bid_o !== 6'(6'h10 + (c - 1) % 8) || bresp_o !== 2'((c - 1) % 8) || buser_o !== 6'(6'h20 + (c - 1) % 8)) begin
                    n_fail++; $display("FAIL rr_resp c=%0d: got v=%b id=%h r=%b u=%h want id=%h", c, bvalid_o, bid_o, bresp_o, buser_o, 6'(6'h10 + (c - 1) % 8));
                end
            end
            tick();
        end
        bvalid_i = '0;
    endtask

    // Master stalls four cycles on slave 3's response; nothing else is granted until the pop.
    task automatic test_stall();
        do_reset();
        tb_bid[3] = 6'h15; tb_bresp[3] = 2'b00;
        bvalid_i = 8'h08; bready_i = 1'b0;
        settle();
        n_checks++; if (bready_o !== 8'h08) begin n_fail++; $display("FAIL stall_grant3: got %h want 08", bready_o); end
        tick();
        bvalid_i = 8'h01;
        for (int c = 0; c < 4; c++) begin
            settle();
            n_checks++; if (bvalid_o !== 1'b1 || bid_o !== 6'h15 || bresp_o !== 2'b00) begin n_fail++; $display("FAIL stall_hold c=%0d: got v=%b id=%h r=%b want v=1 id=15 r=0", c, bvalid_o, bid_o, bresp_o); end
            n_checks++; if (bready_o !== 8'h00) begin n_fail++; $display("FAIL stall_bready c=%0d: got %h want 00", c, bready_o); end
            tick();
        end
        bready_i = 1'b1; settle();
        n_checks++; if (bready_o !== 8'h01) begin n_fail++; $display("FAIL stall_pop_grant: got %h want 01", bready_o); end
        tick();
        bvalid_i = '0; settle();
        n_checks++; if (bvalid_o !== 1'b1 || bid_o !== 6'h10) begin n_fail++; $display("FAIL stall_next: got v=%b id=%h want v=1 id=10", bvalid_o, bid_o); end
        tick();
        n_checks++; if (bvalid_o !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", bvalid_o); end
        tb_bid[3] = 6'h13; tb_bresp[3] = 2'd3;
    endtask

    // Error wins over slaves and does not move the round-robin pointer.
    task automatic test_error();
        do_reset();
        bready_i = 1'b1; bvalid_i = 8'h20;
        error_req_i = 1'b1; error_id_i = 6'h2A; error_user_i = 6'h3C;
        settle();
        n_checks++; if (error_gnt_o !== 1'b1 || bready_o !== 8'h00) begin n_fail++; $display("FAIL err_gnt: got g=%b rdy=%h want g=1 rdy=00", error_gnt_o, bready_o); end
        tick();
        error_req_i = 1'b0; settle();
        n_checks++; if (bvalid_o !== 1'b1 || bid_o !== 6'h2A || bresp_o !== 2'b11 || buser_o !== 6'h3C) begin n_fail++; $display("FAIL err_resp: got v=%b id=%h r=%b u=%h want 1/2a/11/3c", bvalid_o, bid_o, bresp_o, buser_o); end
        n_checks++; if (bready_o !== 8'h20 || error_gnt_o !== 1'b0) begin n_fail++; $display("FAIL err_then_slave5: got rdy=%h g=%b want 20/0", bready_o, error_gnt_o); end
        tick();
        n_checks++; if (bid_o !== 6'h15 || bresp_o !== 2'd1) begin n_fail++; $display("FAIL err_slave5_resp: got id=%h r=%b want 15/01", bid_o, bresp_o); end
        // rr_ptr is now 6: a second error alongside slaves 0 and 6 must leave it there.
        bvalid_i = 8'h41; error_req_i = 1'b1; error_id_i = 6'h07; error_user_i = 6'h01;
        settle();
        n_checks++; if (error_gnt_o !== 1'b1 || bready_o !== 8'h00) begin n_fail++; $display("FAIL err2_gnt: got g=%b rdy=%h want 1/00", error_gnt_o, bready_o); end
        tick();
        error_req_i = 1'b0; settle();
        n_checks++; if (bid_o !== 6'h07 || bresp_o !== 2'b11) begin n_fail++; $display("FAIL err2_resp: got id=%h r=%b want 07/11", bid_o, bresp_o); end
        n_checks++; if (bready_o !== 8'h40) begin n_fail++; $display("FAIL err2_ptr_kept: got %h want 40", bready_o); end
        tick();
        bvalid_i = 8'h01; settle();
        n_checks++; if (bid_o !== 6'h16 || bready_o !== 8'h01) begin n_fail++; $display("FAIL err2_slave6: got id=%h rdy=%h want 16/01", bid_o, bready_o); end
        tick();
        bvalid_i = '0;
    endtask

    // Pointer wraps from 7 to 0: with slaves 7 and 0 both valid after granting 7, slave 0 wins.
    task automatic test_wrap();
        do_reset();
        bready_i = 1'b1; bvalid_i = 8'h40; settle();
        n_checks++; if (bready_o !== 8'h40) begin n_fail++; $display("FAIL wrap_g6: got %h want 40", bready_o); end
        tick();
        bvalid_i = 8'h80; settle();
        n_checks++; if (bready_o !== 8'h80) begin n_fail++; $display("FAIL wrap_g7: got %h want 80", bready_o); end
        tick();
        bvalid_i = 8'h81; settle();
        n_checks++; if (bready_o !== 8'h01 || bid_o !== 6'h17) begin n_fail++; $display("FAIL wrap_g0: got rdy=%h id=%h want 01/17", bready_o, bid_o); end
        tick();
        bvalid_i = '0; settle();
        n_checks++; if (bid_o !== 6'h10 || buser_o !== 6'h20) begin n_fail++; $display("FAIL wrap_resp0: got id=%h u=%h want 10/20", bid_o, buser_o); end
        tick();
    endtask

    // Reset while a stalled response is held: response discarded, pointer back to 0.
    task automatic test_reset_mid();
        do_reset();
        bready_i = 1'b0; bvalid_i = 8'h04; tick();
        bvalid_i = '0; settle();
        n_checks++; if (bvalid_o !== 1'b1 || bid_o !== 6'h12) begin n_fail++; $display("FAIL mid_loaded: got v=%b id=%h want 1/12", bvalid_o, bid_o); end
        rst = 1'b1; bvalid_i = 8'hFF; bready_i = 1'b1; error_req_i = 1'b1; settle();
        n_checks++; if (bready_o !== 8'h00 || error_gnt_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_grants: got rdy=%h g=%b want 00/0", bready_o, error_gnt_o); end
        tick();
        n_checks++; if (bvalid_o !== 1'b0 || {bid_o, bresp_o, buser_o} !== 14'h0) begin n_fail++; $display("FAIL mid_rst_outputs: got v=%b p=%h want 0/0", bvalid_o, {bid_o, bresp_o, buser_o}); end
        rst = 1'b0; error_req_i = 1'b0; bvalid_i = 8'h0C; settle();
        n_checks++; if (bready_o !== 8'h04) begin n_fail++; $display("FAIL mid_rst_ptr: got %h want 04", bready_o); end
        tick();
        bvalid_i = '0; tick();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            tb_bid[k]   = 6'(6'h10 + k);
            tb_bresp[k] = 2'(k);
            tb_buser[k] = 6'(6'h20 + k);
        end
        test_reset();
        test_round_robin();
        test_stall();
        test_error();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
